// File: rtl/gated_frame_builder.sv
// gated_frame_builder
//   Builds frames from a free-running sample stream, gated by a stretched
//   trigger. Frame = header {01, timestamp}, contiguous data words
//   {10, sample} including PRE_LEN samples of pre-trigger history, then
//   footer {11, data-word count (saturating)}.
//
// Ports
//   CLK       in   sole clock, rising edge
//   RESETN    in   async active-low reset
//   PRE_LEN   in   pre-trigger depth, latched at gate rise
//   SIG_GATE  in   stretched trigger
//   DATA_IN   in   one sample per cycle
//   M_DATA    out  {type[1:0], payload}, zero when M_VALID=0
//   M_VALID   out  output word valid (no backpressure)
//   BUSY      out  high header..footer inclusive
//   DROPPED   out  pulse when a rise lands on the footer-load cycle
module gated_frame_builder #(
  parameter int DATA_WIDTH    = 16,
  parameter int PRE_LEN_WIDTH = 4
) (
  input  logic                     CLK,
  input  logic                     RESETN,
  input  logic [PRE_LEN_WIDTH-1:0] PRE_LEN,
  input  logic                     SIG_GATE,
  input  logic [DATA_WIDTH-1:0]    DATA_IN,
  output logic [DATA_WIDTH+1:0]    M_DATA,
  output logic                     M_VALID,
  output logic                     BUSY,
  output logic                     DROPPED
);

  localparam int DEPTH = 1 << PRE_LEN_WIDTH;

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_TRAIL, S_FOOTER} state_e;

  state_e                   state_q, state_d;
  logic [DATA_WIDTH-1:0]    ts_q;
  logic [PRE_LEN_WIDTH-1:0] wp_q;
  logic [DATA_WIDTH-1:0]    ring_q [DEPTH];
  logic                     gate_q;
  logic [PRE_LEN_WIDTH-1:0] pl_q, pl_d;
  logic [PRE_LEN_WIDTH-1:0] trail_q, trail_d;
  logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH+1:0]    mdata_q, mdata_d;
  logic                     mvalid_q, mvalid_d;
  logic                     busy_q;
  logic                     drop_q, drop_d;

  logic                     rise;
  logic [PRE_LEN_WIDTH-1:0] rd_idx;
  logic [DATA_WIDTH+1:0]    data_word;
  logic [DATA_WIDTH-1:0]    cnt_inc;

  assign rise = SIG_GATE & ~gate_q;

  // wp_q is the slot about to be written, so wp_q-1 holds the previous
  // cycle's sample. Emitting sample (now - pl - 1) gives the fixed
  // PRE_LEN+2 input-to-output latency. At pl = DEPTH-1 the tap equals wp_q,
  // which is read before this edge overwrites it.
  assign rd_idx    = wp_q - PRE_LEN_WIDTH'(1) - pl_q;
  assign data_word = {2'b10, ring_q[rd_idx]};
  assign cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + DATA_WIDTH'(1);

  always_comb begin
    state_d  = state_q;
    pl_d     = pl_q;
    trail_d  = trail_q;
    cnt_d    = cnt_q;
    mdata_d  = '0;
    mvalid_d = 1'b0;
    drop_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (rise) begin
          state_d  = S_DATA;
          pl_d     = PRE_LEN;
          cnt_d    = '0;
          mdata_d  = {2'b01, ts_q};
          mvalid_d = 1'b1;
        end
      end
      S_DATA: begin
        mdata_d  = data_word;
        mvalid_d = 1'b1;
        cnt_d    = cnt_inc;
        if (!SIG_GATE) begin
          if (pl_q == '0) begin
            state_d = S_FOOTER;
          end else begin
            state_d = S_TRAIL;
            trail_d = pl_q;
          end
        end
      end
      S_TRAIL: begin
        mdata_d  = data_word;
        mvalid_d = 1'b1;
        cnt_d    = cnt_inc;
        // Gate back high before the history drains: merge into this frame.
        if (SIG_GATE)                          state_d = S_DATA;
        else if (trail_q == PRE_LEN_WIDTH'(1)) state_d = S_FOOTER;
        else                                   trail_d = trail_q - PRE_LEN_WIDTH'(1);
      end
      S_FOOTER: begin
        mdata_d  = {2'b11, cnt_q};
        mvalid_d = 1'b1;
        state_d  = S_IDLE;
        // A rise here cannot start a frame; gate_q still tracks it, so the
        // gate has to fall and rise again.
        drop_d   = rise;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state_q  <= S_IDLE;
      ts_q     <= '0;
      wp_q     <= '0;
      gate_q   <= 1'b0;
      pl_q     <= '0;
      trail_q  <= '0;
      cnt_q    <= '0;
      mdata_q  <= '0;
      mvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      drop_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) ring_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_q + DATA_WIDTH'(1);
      wp_q         <= wp_q + PRE_LEN_WIDTH'(1);
      ring_q[wp_q] <= DATA_IN;
      gate_q       <= SIG_GATE;
      pl_q         <= pl_d;
      trail_q      <= trail_d;
      cnt_q        <= cnt_d;
      mdata_q      <= mdata_d;
      mvalid_q     <= mvalid_d;
      busy_q       <= mvalid_d;
      drop_q       <= drop_d;
    end
  end

  assign M_DATA  = mdata_q;
  assign M_VALID = mvalid_q;
  assign BUSY    = busy_q;
  assign DROPPED = drop_q;

endmodule
